// File: rtl/serial_mag_comp_ctrl.sv
// Serial MSB-first magnitude comparator controller driving one shared 1-bit comparator.
// Define SERIAL_COMP_EARLY_EXIT_EN to finish on the first decisive or erroneous bit.
module serial_mag_comp_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic          busy,
  output logic          done,
  output logic          bit_a,
  output logic          bit_b,
  input  logic          bit_gt,
  input  logic          bit_eq,
  input  logic          bit_lt,
  output logic          a_gt_b,
  output logic          a_eq_b,
  output logic          a_lt_b,
  output logic [CW-1:0] bits_used,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t stateReg, stateNext;

  logic [WIDTH-1:0] aShReg, bShReg;
  logic [CW-1:0]    cntReg;
  logic             decGtReg, decLtReg, errAccReg;
  logic             gtReg, eqReg, ltReg, errReg;
  logic [CW-1:0]    bitsUsedReg;

  logic oneHot, decided, decisiveNow, lastBit, earlyExit, exitNow, accept;
  logic errFinal, gtFinal, ltFinal;

  always_comb begin
    oneHot      = (bit_gt & ~bit_eq & ~bit_lt) |
                  (~bit_gt & bit_eq & ~bit_lt) |
                  (~bit_gt & ~bit_eq & bit_lt);
    decided     = decGtReg | decLtReg;
    decisiveNow = oneHot & ~decided & (bit_gt | bit_lt);
    lastBit     = (cntReg == CW'(WIDTH - 1));
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    earlyExit   = decisiveNow | ~oneHot;
`else
    earlyExit   = 1'b0;
`endif
    exitNow     = lastBit | earlyExit;
    accept      = start & (stateReg != COMPARE);
    errFinal    = errAccReg | ~oneHot;
    gtFinal     = decGtReg | (decisiveNow & bit_gt);
    ltFinal     = decLtReg | (decisiveNow & bit_lt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = COMPARE;
      COMPARE: if (exitNow) stateNext = DONE;
      DONE:    stateNext = accept ? COMPARE : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bit lines are gated by state so the comparator sees zeros outside COMPARE.
  always_comb begin
    busy  = (stateReg == COMPARE);
    done  = (stateReg == DONE);
    bit_a = busy & aShReg[WIDTH-1];
    bit_b = busy & bShReg[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aShReg      <= '0;
      bShReg      <= '0;
      cntReg      <= '0;
      decGtReg    <= 1'b0;
      decLtReg    <= 1'b0;
      errAccReg   <= 1'b0;
      gtReg       <= 1'b0;
      eqReg       <= 1'b0;
      ltReg       <= 1'b0;
      errReg      <= 1'b0;
      bitsUsedReg <= '0;
    end else if (accept) begin
      aShReg      <= a_in;
      bShReg      <= b_in;
      cntReg      <= '0;
      decGtReg    <= 1'b0;
      decLtReg    <= 1'b0;
      errAccReg   <= 1'b0;
      gtReg       <= 1'b0;
      eqReg       <= 1'b0;
      ltReg       <= 1'b0;
      errReg      <= 1'b0;
      bitsUsedReg <= '0;
    end else if (stateReg == COMPARE) begin
      aShReg <= aShReg << 1;
      bShReg <= bShReg << 1;
      cntReg <= cntReg + CW'(1);
      if (!oneHot) begin
        errAccReg <= 1'b1;
      end else if (decisiveNow) begin
        decGtReg <= bit_gt;
        decLtReg <= bit_lt;
      end
      // Results are published only once, on the edge that leaves COMPARE.
      if (exitNow) begin
        gtReg       <= ~errFinal & gtFinal;
        ltReg       <= ~errFinal & ltFinal;
        eqReg       <= ~errFinal & ~gtFinal & ~ltFinal;
        errReg      <= errFinal;
        bitsUsedReg <= cntReg + CW'(1);
      end
    end
  end

  assign a_gt_b    = gtReg;
  assign a_eq_b    = eqReg;
  assign a_lt_b    = ltReg;
  assign err       = errReg;
  assign bits_used = bitsUsedReg;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Directed bench for serial_mag_comp_ctrl with a behavioural 1-bit comparator stub
// and a scoreboard of expected results; follows SERIAL_COMP_EARLY_EXIT_EN if defined.
module tb_serial_mag_comp_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [WIDTH-1:0] a_in, b_in;
  logic busy, done, bit_a, bit_b, bit_gt, bit_eq, bit_lt;
  logic a_gt_b, a_eq_b, a_lt_b, err;
  logic [CW-1:0] bits_used;

  typedef struct {
    logic gt, eq, lt, er;
    int   bu, lat;
    logic [7:0] sa, sb;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  int   nChecks = 0;
  int   nFails  = 0;
  int   injectCycle = -1;
  int   busyCnt = 0;

  serial_mag_comp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .bit_a(bit_a), .bit_b(bit_b),
    .bit_gt(bit_gt), .bit_eq(bit_eq), .bit_lt(bit_lt),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
    .bits_used(bits_used), .err(err)
  );

  always #5 clk = ~clk;

  // Comparator stub: optionally answers gt and lt together on one chosen bit.
  always @(posedge clk) begin
    if (!busy) busyCnt <= 0;
    else       busyCnt <= busyCnt + 1;
  end

  logic inj;
  assign inj    = busy && (busyCnt == injectCycle);
  assign bit_gt = inj ? 1'b1 : (bit_a & ~bit_b);
  assign bit_lt = inj ? 1'b1 : (~bit_a & bit_b);
  assign bit_eq = inj ? 1'b0 : (bit_a == bit_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int injAt);
    exp_t e;
    logic dec, gt, lt, er, exited;
    int k;
    dec = 0; gt = 0; lt = 0; er = 0; exited = 0; k = 8;
    for (int i = 0; i < 8; i++) begin
      if (!exited) begin
        if (i == injAt) begin
          er = 1;
          if (EN) begin k = i + 1; exited = 1; end
        end else if (!dec && a[7-i] != b[7-i]) begin
          dec = 1; gt = a[7-i]; lt = b[7-i];
          if (EN) begin k = i + 1; exited = 1; end
        end
      end
    end
    e.gt  = !er && gt;
    e.lt  = !er && lt;
    e.eq  = !er && !dec;
    e.er  = er;
    e.bu  = k;
    e.lat = k + 1;
    e.sa  = a >> (8 - k);
    e.sb  = b >> (8 - k);
    return e;
  endfunction

  // Called at a negedge: present operands and raise start for the next edge.
  task automatic startOp(input logic [7:0] a, input logic [7:0] b, input int injAt);
    a_in = a; b_in = b; injectCycle = injAt; start = 1'b1;
    expQ.push_back(model(a, b, injAt));
  endtask

  task automatic waitOp(input bit pulse);
    exp_t e;
    int cyc;
    logic [7:0] sa, sb;
    sa = '0; sb = '0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);
    while (!done && cyc < 40) begin
      if (busy) begin
        sa = {sa[6:0], bit_a};
        sb = {sb[6:0], bit_b};
      end
      if (pulse && (cyc == 2 || cyc == 4)) begin
        start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      if (expQ.size() > 0) void'(expQ.pop_front());
      return;
    end
    if (expQ.size() == 0) begin
      check("unexpected_done", 1, 0);
      return;
    end
    e = expQ.pop_front();
    lastExp = e;
    check("latency",   cyc, e.lat);
    check("busy_done", busy, 0);
    check("a_gt_b",    a_gt_b, e.gt);
    check("a_eq_b",    a_eq_b, e.eq);
    check("a_lt_b",    a_lt_b, e.lt);
    check("err",       err, e.er);
    check("bits_used", bits_used, e.bu);
    check("stream_a",  sa, e.sa);
    check("stream_b",  sb, e.sb);
    $display("op done: gt=%0b eq=%0b lt=%0b err=%0b bits_used=%0d latency=%0d",
             a_gt_b, a_eq_b, a_lt_b, err, bits_used, cyc);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, done, bit_a, bit_b, a_gt_b, a_eq_b, a_lt_b, err, 4'(bits_used)}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    startOp(8'hA5, 8'hA5, -1); waitOp(0);
    @(negedge clk);
    startOp(8'h80, 8'h7F, -1); waitOp(0);
    @(negedge clk);
    startOp(8'h7F, 8'h80, -1); waitOp(0);

    // start pulses mid-operation must be ignored
    @(negedge clk);
    startOp(8'h12, 8'h13, -1); waitOp(1);
    // start held in the DONE cycle chains straight into a new operation
    startOp(8'h00, 8'hFF, -1); waitOp(0);

    // results hold after DONE
    repeat (2) @(negedge clk);
    check("hold_done", done, 0);
    check("hold_busy", busy, 0);
    check("hold_lt", a_lt_b, lastExp.lt);
    check("hold_bits_used", bits_used, lastExp.bu);

    // non-one-hot comparator answer on bit 5
    @(negedge clk);
    startOp(8'h3C, 8'h3C, 2); waitOp(0);
    injectCycle = -1;

    // reset in the middle of an operation
    @(negedge clk);
    startOp(8'hA5, 8'h5A, -1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_outs", {busy, done, bit_a, bit_b, a_gt_b, a_eq_b, a_lt_b, err, 4'(bits_used)}, 0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_reset", dones, 0);

    startOp(8'hC3, 8'hC2, -1); waitOp(0);
    check("scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
